// File: rtl/clock_time_ctrl.sv
// Time-of-day keeper for the seven-segment clock: BCD HH:MM:SS counters
// driven by a 1 Hz tick, plus a small set-mode FSM for hours/minutes.
module clock_time_ctrl #(
   parameter int MAX_HOUR  = 23,
   parameter int TIMEOUT_S = 30
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sec_tick,
   input  logic       i_mode_pulse,
   input  logic       i_inc_pulse,
   output logic [1:0] o_hr_tens,
   output logic [3:0] o_hr_ones,
   output logic [2:0] o_min_tens,
   output logic [3:0] o_min_ones,
   output logic [2:0] o_sec_tens,
   output logic [3:0] o_sec_ones,
   output logic [1:0] o_mode,
   output logic       o_blink
);

   // state      | meaning
   // ST_RUN     | time advances on each second tick, buttons other than mode ignored
   // ST_SET_HR  | time frozen, increment bumps hours, blink/timeout on ticks
   // ST_SET_MIN | time frozen, increment bumps minutes (no hour carry)
   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_SET_HR  = 2'b01,
      ST_SET_MIN = 2'b10
   } state_t;

   localparam logic [1:0] MAX_HR_TENS = 2'(MAX_HOUR / 10);
   localparam logic [3:0] MAX_HR_ONES = 4'(MAX_HOUR % 10);
   localparam logic [5:0] TIMEOUT_V   = 6'(TIMEOUT_S);

   state_t     state;
   state_t     state_nxt;
   logic       mode_prev;
   logic       inc_prev;
   logic       mode_ev;
   logic       inc_ev;
   logic [5:0] to_cnt;
   logic       timeout_hit;
   logic       enter_run;

   logic       sec_wrap;
   logic       min_wrap;
   logic       hr_wrap;
   logic [2:0] min_tens_nxt;
   logic [3:0] min_ones_nxt;
   logic [1:0] hr_tens_nxt;
   logic [3:0] hr_ones_nxt;

   assign mode_ev = i_mode_pulse & ~mode_prev;
   assign inc_ev  = i_inc_pulse & ~inc_prev;

   // A button event in the same cycle pre-empts the timeout
   assign timeout_hit = (state != ST_RUN) & i_sec_tick & ~mode_ev & ~inc_ev &
                        ((to_cnt + 6'd1) == TIMEOUT_V);

   assign sec_wrap = (o_sec_tens == 3'd5) && (o_sec_ones == 4'd9);
   assign min_wrap = (o_min_tens == 3'd5) && (o_min_ones == 4'd9);
   assign hr_wrap  = (o_hr_tens == MAX_HR_TENS) && (o_hr_ones == MAX_HR_ONES);

   always_comb begin
      min_tens_nxt = o_min_tens;
      min_ones_nxt = o_min_ones + 4'd1;
      if (min_wrap) begin
         min_tens_nxt = 3'd0;
         min_ones_nxt = 4'd0;
      end else if (o_min_ones == 4'd9) begin
         min_tens_nxt = o_min_tens + 3'd1;
         min_ones_nxt = 4'd0;
      end
   end

   always_comb begin
      hr_tens_nxt = o_hr_tens;
      hr_ones_nxt = o_hr_ones + 4'd1;
      if (hr_wrap) begin
         hr_tens_nxt = 2'd0;
         hr_ones_nxt = 4'd0;
      end else if (o_hr_ones == 4'd9) begin
         hr_tens_nxt = o_hr_tens + 2'd1;
         hr_ones_nxt = 4'd0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (mode_ev) begin
         case (state)
            ST_RUN:    state_nxt = ST_SET_HR;
            ST_SET_HR: state_nxt = ST_SET_MIN;
            default:   state_nxt = ST_RUN;
         endcase
      end else if (timeout_hit || (state != ST_RUN && state != ST_SET_HR &&
                                   state != ST_SET_MIN)) begin
         state_nxt = ST_RUN;
      end
   end

   always_comb begin
      o_mode = state;
   end

   assign enter_run = (state_nxt == ST_RUN) && (state != ST_RUN);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_prev  <= 1'b0;
         inc_prev   <= 1'b0;
         to_cnt     <= 6'd0;
         o_blink    <= 1'b0;
         o_hr_tens  <= 2'd0;
         o_hr_ones  <= 4'd0;
         o_min_tens <= 3'd0;
         o_min_ones <= 4'd0;
         o_sec_tens <= 3'd0;
         o_sec_ones <= 4'd0;
      end else begin
         mode_prev <= i_mode_pulse;
         inc_prev  <= i_inc_pulse;
         if (enter_run) begin
            o_sec_tens <= 3'd0;
            o_sec_ones <= 4'd0;
            to_cnt     <= 6'd0;
            o_blink    <= 1'b0;
         end else if (mode_ev) begin
            to_cnt  <= 6'd0;
            o_blink <= 1'b1;
         end else if (state == ST_RUN) begin
            if (i_sec_tick) begin
               if (sec_wrap) begin
                  o_sec_tens <= 3'd0;
                  o_sec_ones <= 4'd0;
                  o_min_tens <= min_tens_nxt;
                  o_min_ones <= min_ones_nxt;
                  if (min_wrap) begin
                     o_hr_tens <= hr_tens_nxt;
                     o_hr_ones <= hr_ones_nxt;
                  end
               end else if (o_sec_ones == 4'd9) begin
                  o_sec_tens <= o_sec_tens + 3'd1;
                  o_sec_ones <= 4'd0;
               end else begin
                  o_sec_ones <= o_sec_ones + 4'd1;
               end
            end
         end else begin
            // Set modes: an increment clears the idle count; a tick still flips blink
            if (inc_ev) begin
               to_cnt <= 6'd0;
               if (state == ST_SET_HR) begin
                  o_hr_tens <= hr_tens_nxt;
                  o_hr_ones <= hr_ones_nxt;
               end else begin
                  o_min_tens <= min_tens_nxt;
                  o_min_ones <= min_ones_nxt;
               end
            end else if (i_sec_tick) begin
               to_cnt <= to_cnt + 6'd1;
            end
            if (i_sec_tick) begin
               o_blink <= ~o_blink;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: a time-of-day model predicts each
// cycle's outputs; a monitor pops and compares after every clock edge.
module tb_clock_time_ctrl;

   localparam int MAX_HOUR  = 23;
   localparam int TIMEOUT_S = 30;

   logic       clk;
   logic       rst_n;
   logic       sec_tick;
   logic       mode_pulse;
   logic       inc_pulse;
   logic [1:0] hr_tens;
   logic [3:0] hr_ones;
   logic [2:0] min_tens;
   logic [3:0] min_ones;
   logic [2:0] sec_tens;
   logic [3:0] sec_ones;
   logic [1:0] mode;
   logic       blink;

   clock_time_ctrl #(.MAX_HOUR(MAX_HOUR), .TIMEOUT_S(TIMEOUT_S)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sec_tick   (sec_tick),
      .i_mode_pulse (mode_pulse),
      .i_inc_pulse  (inc_pulse),
      .o_hr_tens    (hr_tens),
      .o_hr_ones    (hr_ones),
      .o_min_tens   (min_tens),
      .o_min_ones   (min_ones),
      .o_sec_tens   (sec_tens),
      .o_sec_ones   (sec_ones),
      .o_mode       (mode),
      .o_blink      (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [22:0] sb[$];

   // reference model: plain integers for time, mode 0/1/2
   int m_h, m_m, m_s, m_mode, m_blink, m_cnt;
   bit p_mode, p_inc;

   function automatic logic [22:0] act_vec();
      return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, mode, blink};
   endfunction

   function automatic logic [22:0] exp_vec();
      return {2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
              3'(m_s / 10), 4'(m_s % 10), 2'(m_mode), 1'(m_blink)};
   endfunction

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_cnt = 0;
      p_mode = 0; p_inc = 0;
   endtask

   task automatic model_step(input bit t, input bit md, input bit in);
      bit mev, iev;
      mev = md && !p_mode;
      iev = in && !p_inc;
      p_mode = md;
      p_inc  = in;
      if (mev) begin
         m_cnt = 0;
         if (m_mode == 2) begin
            m_mode = 0; m_s = 0; m_blink = 0;
         end else begin
            m_mode = m_mode + 1; m_blink = 1;
         end
      end else if (m_mode == 0) begin
         if (t) begin
            m_s++;
            if (m_s == 60) begin
               m_s = 0; m_m++;
               if (m_m == 60) begin
                  m_m = 0;
                  m_h = (m_h + 1) % (MAX_HOUR + 1);
               end
            end
         end
      end else if (iev) begin
         m_cnt = 0;
         if (m_mode == 1) m_h = (m_h + 1) % (MAX_HOUR + 1);
         else             m_m = (m_m + 1) % 60;
         if (t) m_blink = 1 - m_blink;
      end else if (t) begin
         if (m_cnt + 1 == TIMEOUT_S) begin
            m_mode = 0; m_s = 0; m_blink = 0; m_cnt = 0;
         end else begin
            m_cnt++;
            m_blink = 1 - m_blink;
         end
      end
   endtask

   task automatic step(input bit t, input bit md, input bit in);
      @(negedge clk);
      sec_tick   = t;
      mode_pulse = md;
      inc_pulse  = in;
      model_step(t, md, in);
      sb.push_back(exp_vec());
   endtask

   task automatic press_mode();
      step(0, 1, 0);
      step(0, 0, 0);
   endtask

   task automatic press_inc();
      step(0, 0, 1);
      step(0, 0, 0);
   endtask

   task automatic tick1();
      step(1, 0, 0);
      step(0, 0, 0);
   endtask

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // monitor: outputs settle after each edge; compare against the queued prediction
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            logic [22:0] e;
            e = sb.pop_front();
            check("sb", act_vec(), e);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sec_tick = 0; mode_pulse = 0; inc_pulse = 0;
      rst_n = 0;
      model_reset();
      #22;
      check("reset", act_vec(), exp_vec());
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 3661; i++) tick1();

      // preload 23:59:58 through the set modes, then roll over
      press_mode();
      for (int i = 0; i < 30 && m_h != 23; i++) press_inc();
      press_mode();
      for (int i = 0; i < 70 && m_m != 59; i++) press_inc();
      press_mode();
      for (int i = 0; i < 58; i++) tick1();
      tick1();
      tick1();

      // long-held buttons give exactly one event each
      for (int i = 0; i < 5000; i++) step(0, 1, 0);
      step(0, 0, 0);
      for (int i = 0; i < 30 && m_h != 22; i++) press_inc();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 5000; i++) step(0, 0, 1);
         step(0, 0, 0);
      end

      press_mode();
      for (int i = 0; i < 61; i++) press_inc();
      press_mode();

      // set-mode timeout
      press_mode();
      for (int i = 0; i < 29; i++) tick1();
      press_inc();
      for (int i = 0; i < 30; i++) tick1();

      // simultaneous events
      press_mode();
      step(0, 1, 1);
      step(0, 0, 0);
      step(1, 0, 1);
      step(0, 0, 0);
      step(1, 1, 0);
      step(0, 0, 0);

      // randomized: single-cycle ticks, random-length button holds
      begin
         bit t, md, in;
         md = 0; in = 0; t = 0;
         for (int i = 0; i < 4000; i++) begin
            t = !t && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) md = !md;
            if ($urandom_range(0, 6) == 0)  in = !in;
            step(t, md, in);
         end
         step(0, 0, 0);
      end

      // enter a set mode, then abandon it with a mid-cycle async reset
      for (int i = 0; i < 3 && m_mode == 0; i++) press_mode();
      press_inc();
      @(posedge clk);
      #3;
      rst_n = 0;
      model_reset();
      #1;
      check("async_reset", act_vec(), exp_vec());
      @(negedge clk);
      rst_n = 1;
      tick1();
      tick1();

      @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Consumes the single-event pulses from the button debouncers (mode and increment buttons) plus a 1 Hz tick.
- Keeps the running HH:MM:SS time of day as registered BCD digits for the seven-segment display driver.
- Runs a small set-mode FSM that lets the user adjust hours and minutes.
- Sits directly downstream of the two button debouncers and upstream of the display multiplexer.

Parameters:
- MAX_HOUR, 23, highest hour value before wrap to 0 (legal 1..23, binary integer).
- TIMEOUT_S, 30, number of i_sec_tick pulses without a button event in a set mode before automatic return to RUN (legal 1..63).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; one clock, asynchronous, active-low.
- i_sec_tick  input  1  1 Hz enable, exactly one i_clk cycle wide.
- i_mode_pulse  input  1  debounced mode button pulse; may stay high for many i_clk cycles.
- i_inc_pulse  input  1  debounced increment button pulse; may stay high for many i_clk cycles.
- o_hr_tens  output  2  hours tens digit, BCD.
- o_hr_ones  output  4  hours ones digit, BCD.
- o_min_tens  output  3  minutes tens digit, BCD.
- o_min_ones  output  4  minutes ones digit, BCD.
- o_sec_tens  output  3  seconds tens digit, BCD.
- o_sec_ones  output  4  seconds ones digit, BCD.
- o_mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven.
- o_blink  output  1  flash phase for the field being set; 0 in RUN.

Behaviour:
- Reset (async, i_rst_n=0): time 00:00:00, o_mode=RUN, o_blink=0, timeout counter=0, edge-detect registers=0. All outputs are registered and hold these values until the first i_clk edge after reset release.
- Button inputs are level-held for one debounce enable period, so the block acts only on their rising edges.
  - Each input is registered (prev) on every i_clk.
  - An event is input=1 and prev=0, giving exactly one event per assertion.
  - State and digits update on the same i_clk edge that detects the event, so outputs change one cycle after the input is first high.
- i_sec_tick is used as a level, with no edge detection.
- FSM, on a mode event: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN.
- On every entry to RUN (mode event or timeout): seconds cleared to 00 on the same edge, and the timeout counter cleared.
- RUN:
  - i_sec_tick increments seconds 59->00 with carry to minutes.
  - Minutes 59->00 with carry to hours.
  - Hours MAX_HOUR->00.
  - Default rollover is 23:59:59 -> 00:00:00 in one cycle.
  - Increment events are ignored.
  - o_blink=0.
- SET_HR:
  - Time does not advance.
  - An increment event adds 1 to hours, wrapping MAX_HOUR->00.
  - Minutes and seconds are unchanged.
- SET_MIN:
  - Time does not advance.
  - An increment event adds 1 to minutes, wrapping 59->00, with no carry into hours.
- Set-mode timeout:
  - In SET_HR or SET_MIN, each i_sec_tick increments the timeout counter and toggles o_blink.
  - Any button event clears the counter to 0.
  - When a tick would make the counter equal TIMEOUT_S, the FSM goes to RUN on that edge: seconds cleared, o_blink=0.
- Entering SET_HR from RUN: o_blink=1 and timeout counter=0.
- Simultaneous events in the same cycle:
  - Mode and increment together: mode wins, increment is discarded.
  - Button event and i_sec_tick together: button is handled, and the tick is applied only to blink/timeout (the counter is cleared by the event, then not incremented).
- Digit arithmetic is done directly in BCD with per-digit compare. Hours compare {tens,ones} against MAX_HOUR converted to BCD at elaboration.
- Asserting reset mid-set abandons the edit immediately: time 00:00:00, mode RUN.

Test Plan:
- Reset, then 3661 i_sec_tick pulses in RUN -> display 01:01:01, o_mode=00, o_blink=0 throughout.
- Preload 23:59:58 via set mode, then 2 ticks -> 23:59:59, then 00:00:00 on the second tick edge; all six digits change on the same cycle.
- i_mode_pulse held high for 5000 i_clk cycles -> exactly one transition RUN->SET_HR. Hours at 22, i_inc_pulse held 5000 cycles twice -> 23 then 00, with only one increment per assertion.
- Sequence mode, mode, then inc x61 from minute 00 -> minutes 01 with no hour carry. Third mode event -> o_mode=00 and seconds=00.
- In SET_HR, 29 ticks -> still SET_HR with o_blink toggled 29 times. Button event resets the count. 30 ticks with no event -> o_mode=00 on the 30th tick edge.
- Mode and inc rising in the same cycle in SET_HR -> o_mode=10, hours unchanged. i_rst_n pulsed low mid-set -> outputs 00:00:00, o_mode=00 asynchronously, without waiting for a clock edge.
